// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer and its program RAM.
package program_sequencer_pkg;

    localparam int unsigned DEFAULT_ADDR_W  = 5;
    localparam int unsigned DEFAULT_TIMEOUT = 7;
    localparam int unsigned WORD_W          = 16;

    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 13;
    localparam logic [OP_MSB-OP_LSB:0] OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_END   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/program_sequencer_prog_ram.sv
// Program store: synchronous write, asynchronous read.
module prog_ram
    import program_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              Clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/program_sequencer.sv
// Feeds instruction and mvi immediate words to the core, stepping on Done,
// with a last-address stop and a fault on protocol violations or core stalls.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [WORD_W-1:0] LoadData,
    input  logic              Start,
    input  logic [ADDR_W-1:0] LastAddr,
    input  logic              Done,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Finished,
    output logic              Fault,
    output logic [ADDR_W-1:0] Pc,
    output logic [WORD_W-1:0] Retired
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t            state, next_state;
    logic [ADDR_W-1:0] last_addr, last_next, pc_next;
    logic [WD_W-1:0]   wd, wd_next;
    logic [WORD_W-1:0] retired_next, ram_rd_c;
    logic              stopped_c, is_mvi_c, at_last_c, active_next_c;

    assign stopped_c = (state == ST_IDLE) || (state == ST_END) || (state == ST_FAULT);
    assign is_mvi_c  = (ram_rd_c[OP_MSB:OP_LSB] == OP_MVI);
    assign at_last_c = (Pc == last_addr);

    prog_ram #(.ADDR_W(ADDR_W)) u_ram (
        .Clock     (Clock),
        .wr_en     (LoadEn && stopped_c),
        .wr_addr   (LoadAddr),
        .wr_data   (LoadData),
        .rd_addr   (Pc),
        .rd_data_c (ram_rd_c)
    );

    // The word under Pc goes straight to the core so a same-edge Pc step is seen at once.
    assign DIN = ((state == ST_FETCH) || (state == ST_EXEC)) ? ram_rd_c : '0;

    always_comb begin
        next_state   = state;
        pc_next      = Pc;
        wd_next      = '0;
        retired_next = Retired;
        last_next    = last_addr;
        case (state)
            ST_IDLE, ST_END, ST_FAULT: begin
                if (Start) begin
                    next_state   = ST_FETCH;
                    pc_next      = '0;
                    retired_next = '0;
                    last_next    = LastAddr;
                end
            end
            ST_FETCH: begin
                if (Done) begin
                    next_state = ST_FAULT;
                end else if (is_mvi_c && at_last_c) begin
                    next_state = ST_FAULT;
                end else begin
                    next_state = ST_EXEC;
                    if (is_mvi_c) begin
                        pc_next = Pc + ADDR_W'(1);
                    end
                end
            end
            ST_EXEC: begin
                if (Done) begin
                    if (Retired != '1) begin
                        retired_next = Retired + WORD_W'(1);
                    end
                    if (at_last_c) begin
                        next_state = ST_END;
                    end else begin
                        next_state = ST_FETCH;
                        pc_next    = Pc + ADDR_W'(1);
                    end
                end else begin
                    wd_next = wd + WD_W'(1);
                    if (wd == WD_W'(TIMEOUT - 1)) begin
                        next_state = ST_FAULT;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign active_next_c = (next_state == ST_FETCH) || (next_state == ST_EXEC);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            Pc        <= '0;
            wd        <= '0;
            Retired   <= '0;
            last_addr <= '0;
            Run       <= 1'b0;
            Busy      <= 1'b0;
            Finished  <= 1'b0;
            Fault     <= 1'b0;
        end else begin
            state     <= next_state;
            Pc        <= pc_next;
            wd        <= wd_next;
            Retired   <= retired_next;
            last_addr <= last_next;
            Run       <= active_next_c;
            Busy      <= active_next_c;
            Finished  <= (next_state == ST_END) && (state != ST_END);
            Fault     <= (next_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a transaction-level model expands each program
// into the per-cycle DIN/Done trace and the final Pc/Retired/outcome.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    localparam int unsigned AW    = 5;
    localparam int          TO    = 7;
    localparam int          DEPTH = 32;

    logic          Clock = 1'b0;
    logic          Reset, LoadEn, Start, Done;
    logic [AW-1:0] LoadAddr, LastAddr, Pc;
    logic [15:0]   LoadData, DIN, Retired;
    logic          Run, Busy, Finished, Fault;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [15:0] ref_mem [DEPTH];
    int          delays  [DEPTH];
    logic [15:0] exp_din [$];
    bit          exp_done[$];
    int          exp_ret, exp_pc;
    bit          exp_fault;

    program_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .Start(Start), .LastAddr(LastAddr), .Done(Done),
        .DIN(DIN), .Run(Run), .Busy(Busy), .Finished(Finished), .Fault(Fault),
        .Pc(Pc), .Retired(Retired)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input int addr, input logic [15:0] data);
        LoadEn = 1'b1; LoadAddr = AW'(addr); LoadData = data;
        ref_mem[addr] = data;
        tick();
        LoadEn = 1'b0;
    endtask

    // Expand the program into cycles: a fetch cycle, then exec cycles until the
    // core's Done (delays[k] = exec cycles incl. Done; > TO means the core stalls).
    task automatic build_model(input int last);
        int pc = 0;
        int k = 0;
        int n;
        int d;
        logic [15:0] w;
        exp_din.delete(); exp_done.delete();
        exp_ret = 0; exp_fault = 1'b0;
        forever begin
            w = ref_mem[pc];
            exp_din.push_back(w); exp_done.push_back(1'b0);
            if (w[15:13] == 3'b001) begin
                if (pc == last) begin exp_fault = 1'b1; break; end
                pc = (pc + 1) % DEPTH;
                w = ref_mem[pc];
            end
            d = delays[k]; k++;
            n = (d > TO) ? TO : d;
            for (int j = 1; j <= n; j++) begin
                exp_din.push_back(w); exp_done.push_back(j == d);
            end
            if (d > TO) begin exp_fault = 1'b1; break; end
            if (exp_ret < 65535) exp_ret++;
            if (pc == last) break;
            pc = (pc + 1) % DEPTH;
        end
        exp_pc = pc;
    endtask

    task automatic run_prog(input int last, input int disturb, input bit load0,
                            input logic [15:0] load0_data);
        if (load0) ref_mem[0] = load0_data;
        build_model(last);
        Start = 1'b1; LastAddr = AW'(last);
        if (load0) begin LoadEn = 1'b1; LoadAddr = '0; LoadData = load0_data; end
        tick();
        Start = 1'b0; LoadEn = 1'b0;
        for (int i = 0; i < exp_din.size(); i++) begin
            Done = exp_done[i];
            if (i == disturb) begin
                LoadEn = 1'b1; LoadAddr = AW'(2); LoadData = ~ref_mem[2];
                Start = 1'b1; LastAddr = '0;
            end
            check("din", 32'(DIN), 32'(exp_din[i]));
            check("run", 32'(Run), 32'd1);
            check("busy", 32'(Busy), 32'd1);
            tick();
            LoadEn = 1'b0; Start = 1'b0;
        end
        Done = 1'b0;
        check("fault_end", 32'(Fault), 32'(exp_fault));
        check("finished_pulse", 32'(Finished), 32'(!exp_fault));
        check("run_end", 32'(Run), 32'd0);
        check("din_end", 32'(DIN), 32'd0);
        check("retired", 32'(Retired), 32'(exp_ret));
        check("pc", 32'(Pc), 32'(exp_pc));
        tick();
        check("finished_once", 32'(Finished), 32'd0);
        check("fault_hold", 32'(Fault), 32'(exp_fault));
    endtask

    initial begin
        logic [15:0] w;
        int          last;
        Reset = 1'b1; LoadEn = 1'b0; Start = 1'b0; Done = 1'b0;
        LoadAddr = '0; LastAddr = '0; LoadData = '0;
        tick(); tick();
        check("rst_run", 32'(Run), 32'd0);
        check("rst_din", 32'(DIN), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_finished", 32'(Finished), 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        check("rst_pc", 32'(Pc), 32'd0);
        check("rst_retired", 32'(Retired), 32'd0);
        Reset = 1'b0;

        // Reference program: mvi, imm, mvi, imm, add
        for (int a = 0; a < DEPTH; a++) load(a, 16'h0000);
        load(0, 16'h2000); load(1, 16'h0005); load(2, 16'h2400);
        load(3, 16'h0003); load(4, 16'h4080);
        for (int a = 0; a < DEPTH; a++) delays[a] = 1;
        delays[2] = 3;
        run_prog(4, -1, 1'b0, 16'h0);

        // mvi at the last address
        run_prog(0, -1, 1'b0, 16'h0);

        // Core never answers
        load(0, 16'h4080);
        delays[0] = 1000;
        run_prog(0, -1, 1'b0, 16'h0);

        // Load and Start while busy are ignored; rerun confirms the RAM
        load(0, 16'h2000);
        delays[0] = 1;
        run_prog(4, 3, 1'b0, 16'h0);
        run_prog(4, -1, 1'b0, 16'h0);

        // Reset in the middle of an EXEC
        Start = 1'b1; LastAddr = AW'(4);
        tick();
        Start = 1'b0;
        tick(); tick();
        check("mid_exec_run", 32'(Run), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("reset_run", 32'(Run), 32'd0);
        check("reset_din", 32'(DIN), 32'd0);
        check("reset_pc", 32'(Pc), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        run_prog(4, -1, 1'b0, 16'h0);

        // Done during FETCH
        Start = 1'b1; LastAddr = AW'(4);
        tick();
        Start = 1'b0; Done = 1'b1;
        tick();
        Done = 1'b0;
        check("fetch_done_fault", 32'(Fault), 32'd1);
        check("fetch_done_run", 32'(Run), 32'd0);

        // Start and a write to address 0 in the same cycle
        run_prog(4, -1, 1'b1, 16'h4123);

        // Random programs
        for (int r = 0; r < 25; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 2) == 0) w[15:13] = 3'b001;
                load(a, w);
                delays[a] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(8, 12))
                                                         : int'($urandom_range(1, 7));
            end
            last = int'($urandom_range(0, DEPTH - 1));
            w = 16'($urandom);
            run_prog(last, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 12)),
                     1'($urandom_range(0, 1)), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction feeder that sits directly upstream of the processor core. It holds a small program RAM, drives the core's `DIN` and `Run` inputs, and watches `Done` to step through the program. It supplies the extra immediate word for `mvi`, stops after a programmed last address, and reports a fault on protocol violations or when the core stalls.

## Interface
- `ADDR_W`, 5: program RAM address width; depth is 2^ADDR_W words of 16 bits.
- `TIMEOUT`, 7: maximum number of cycles spent in EXEC without `Done` before a fault is raised.
- `Clock` in 1: the single clock; everything is updated on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `LoadEn` in 1: write strobe for the program RAM.
- `LoadAddr` in ADDR_W: write address.
- `LoadData` in 16: write data.
- `Start` in 1: begin execution at address 0.
- `LastAddr` in ADDR_W: address of the final program word; sampled when `Start` is accepted.
- `Done` in 1: instruction-complete strobe from the core.
- `DIN` out 16: instruction or immediate word driven to the core.
- `Run` out 1: execute-enable to the core.
- `Busy` out 1: high in FETCH and EXEC.
- `Finished` out 1: one-cycle pulse on entry to END.
- `Fault` out 1: high while in FAULT.
- `Pc` out ADDR_W: current program counter.
- `Retired` out 16: number of completed instructions; saturates at 16'hFFFF.

## Operation
- States: IDLE, FETCH, EXEC, END, FAULT.
- Reset: state goes to IDLE. `Pc`=0, `Retired`=0, watchdog=0, `Run`=0, `DIN`=0, `Busy`=0, `Finished`=0, `Fault`=0. RAM contents are not reset.
- `DIN` in FETCH and EXEC is `mem[Pc]`, read asynchronously. In IDLE, END and FAULT, `DIN`=0.
- `Run`=1 only in FETCH and EXEC.
- Loading: writes are accepted only in IDLE, END or FAULT. `LoadEn` is ignored while `Busy` is high.
- Starting: `Start` in IDLE, END or FAULT captures `LastAddr`, clears `Pc`, `Retired` and the watchdog, and moves to FETCH. `Start` while `Busy` is ignored.
- If `Start` and `LoadEn` are asserted in the same cycle, the write lands and execution starts. A write to address 0 is visible in the first FETCH.
- FETCH lasts exactly one cycle and presents the instruction word.
  - Opcode is `DIN[15:13]`.
  - If the opcode is `mvi` (3'b001) and `Pc`≠`LastAddr`: `Pc`←`Pc`+1, then go to EXEC, so the immediate word is on `DIN` from the next cycle.
  - If the opcode is `mvi` and `Pc`==`LastAddr`: go to FAULT, because the immediate is missing.
  - Otherwise `Pc` is held and the state goes to EXEC.
  - `Done` seen in FETCH: go to FAULT.
- EXEC holds `DIN` and `Run`, and the watchdog increments each cycle.
  - On `Done`: `Retired`++ (saturating) and the watchdog clears.
  - Then, if `Pc`==`LastAddr`: go to END.
  - Otherwise: `Pc`←`Pc`+1 and go to FETCH. The next instruction is on `DIN` in the cycle right after `Done`, which is when the core is back at its step 0.
  - If the watchdog reaches `TIMEOUT` without `Done`: go to FAULT.
- `Pc` arithmetic is modulo 2^ADDR_W. Wrap can only occur when `LastAddr`=2^ADDR_W−1, and never past `LastAddr`.
- END and FAULT hold `Pc` and `Retired` for inspection. Leaving either state requires `Start` or `Reset`.
- Reset during execution takes priority over everything else. `Run` is low in the cycle after the reset edge.

## Timing
- Latency from the `Start` edge to the first `Run`=1: 1 cycle.
- A non-`mvi` instruction occupies FETCH (1 cycle) plus EXEC (cycles up to and including `Done`).
- An `mvi` instruction presents the instruction word for 1 cycle, then the immediate word until `Done`.
- The gap between an instruction's `Done` and the next FETCH is 0 cycles, so `Run` stays continuously high across the program.
- `Finished` is asserted in the first END cycle only.
- `Done` is sampled only on the clock edge. A `Done` that is high for several cycles counts once per EXEC entry, because the state leaves EXEC on the first one.

## Structure
- Shared package contains:
  - the state encoding;
  - `OP_MVI`=3'b001;
  - opcode field position [15:13];
  - default `ADDR_W` and `TIMEOUT`.
- Sub-module `prog_ram`: 2^ADDR_W×16, synchronous write, asynchronous read. The rest (FSM, `Pc`, watchdog, retire counter) lives in `program_sequencer`.

## Test plan
- Program 16'h2000, 16'h0005, 16'h2400, 16'h0003, 16'h4080 with `LastAddr`=4, and a core model that pulses `Done` 1 cycle after FETCH for `mvi` and 3 cycles after for `add`. Expect:
  - `DIN` sequence 2000, 0005, 2400, 0003, 4080;
  - `Run` high without gaps;
  - `Finished` pulse once;
  - `Retired`=3, `Pc`=4.
- `LastAddr`=0 with word 16'h2000 (`mvi` at the last address): FAULT one cycle after FETCH, `Run` drops, `Retired`=0.
- Core model that never pulses `Done`: `Fault` rises after FETCH plus `TIMEOUT` (7) EXEC cycles, and `Pc` is unchanged.
- `Reset` asserted in the middle of an EXEC: the next cycle shows IDLE, `Run`=0, `DIN`=0, `Pc`=0. A following `Start` reruns from address 0 with the RAM contents intact.
- `LoadEn` to address 2 while `Busy`: RAM unchanged, verified by a rerun. `Start` pulsed during EXEC: ignored.
- `Done` forced high during FETCH: FAULT on the next cycle.
